// File: rtl/mic1_mem_pkg.sv
// Shared types for the MIC-1 main-memory arbiter: requester ids, FSM states
// and the big-endian fetch byte-lane helper.
package mic1_mem_pkg;

    typedef enum logic [1:0] {
        PORT_HOST,
        PORT_DATA,
        PORT_FETCH
    } port_id_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } arb_state_t;

    localparam int WORD_BYTES = 4;

    // Byte 0 of a word lives in bits [31:24] (big-endian lane order).
    function automatic logic [7:0] fetch_byte(input logic [31:0] word,
                                              input logic [1:0]  sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mic1_rr_pick2.sv
// Two-way round-robin chooser between the CPU data and fetch ports.
// Only meaningful when at least one request is present.
module mic1_rr_pick2
    import mic1_mem_pkg::*;
(
    input  logic     data_req,
    input  logic     fetch_req,
    input  port_id_t rr_last,
    output port_id_t grant
);

    always_comb begin
        grant = PORT_FETCH;
        if (data_req && !(fetch_req && rr_last == PORT_DATA)) begin
            grant = PORT_DATA;
        end
    end

endmodule

// File: rtl/mic1_mem_arbiter.sv
// Single-port main-memory arbiter for the MIC-1 SoC: host has absolute
// priority, CPU data and fetch ports share the rest by round-robin.
//
//   state  | meaning
//   IDLE   | sample requests, launch the winner's access (mem_en next cycle)
//   ACCESS | access on the bus this cycle; next cycle acks and returns data
module mic1_mem_arbiter
    import mic1_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,

    input  logic              fetch_req,
    input  logic [ADDR_W+1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [7:0]        fetch_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    arb_state_t state_q, state_d;
    port_id_t   gnt_q, gnt_d;
    port_id_t   rr_last_q, rr_last_d;
    port_id_t   rr_grant;
    logic [1:0] sel_q, sel_d;

    logic              mem_en_d, mem_we_d, busy_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              host_ack_d, data_ack_d, fetch_ack_d;
    logic [DATA_W-1:0] host_rdata_d, data_rdata_d;
    logic [7:0]        fetch_rdata_d;

    mic1_rr_pick2 u_rr (
        .data_req  (data_req),
        .fetch_req (fetch_req),
        .rr_last   (rr_last_q),
        .grant     (rr_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        sel_d         = sel_q;
        rr_last_d     = rr_last_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        busy_d        = busy;
        host_ack_d    = 1'b0;
        data_ack_d    = 1'b0;
        fetch_ack_d   = 1'b0;
        host_rdata_d  = host_rdata;
        data_rdata_d  = data_rdata;
        fetch_rdata_d = fetch_rdata;

        case (state_q)
            IDLE: begin
                if (host_req) begin
                    gnt_d       = PORT_HOST;
                    mem_en_d    = 1'b1;
                    mem_we_d    = host_we;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                    busy_d      = 1'b1;
                    state_d     = ACCESS;
                end else if (data_req || fetch_req) begin
                    gnt_d    = rr_grant;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ACCESS;
                    if (rr_grant == PORT_DATA) begin
                        mem_we_d    = data_we;
                        mem_addr_d  = data_addr;
                        mem_wdata_d = data_wdata;
                    end else begin
                        mem_addr_d  = fetch_addr[ADDR_W+1:2];
                        mem_wdata_d = '0;
                        sel_d       = fetch_addr[1:0];
                    end
                end
            end
            ACCESS: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                case (gnt_q)
                    PORT_HOST: begin
                        host_ack_d = 1'b1;
                        if (!mem_we) host_rdata_d = mem_rdata;
                    end
                    PORT_DATA: begin
                        data_ack_d = 1'b1;
                        rr_last_d  = PORT_DATA;
                        if (!mem_we) data_rdata_d = mem_rdata;
                    end
                    default: begin
                        fetch_ack_d   = 1'b1;
                        rr_last_d     = PORT_FETCH;
                        fetch_rdata_d = fetch_byte(mem_rdata, sel_q);
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= PORT_HOST;
            sel_q       <= 2'd0;
            rr_last_q   <= PORT_FETCH;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            host_ack    <= 1'b0;
            data_ack    <= 1'b0;
            fetch_ack   <= 1'b0;
            host_rdata  <= '0;
            data_rdata  <= '0;
            fetch_rdata <= '0;
        end else begin
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            rr_last_q   <= rr_last_d;
            mem_en      <= mem_en_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            busy        <= busy_d;
            host_ack    <= host_ack_d;
            data_ack    <= data_ack_d;
            fetch_ack   <= fetch_ack_d;
            host_rdata  <= host_rdata_d;
            data_rdata  <= data_rdata_d;
            fetch_rdata <= fetch_rdata_d;
        end
    end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed bench for mic1_mem_arbiter with a simple word memory model whose
// read data follows mem_addr during the access cycle.
module tb_mic1_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        host_req, host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        data_req, data_we;
    logic [15:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        fetch_req;
    logic [17:0] fetch_addr;
    logic        fetch_ack;
    logic [7:0]  fetch_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:65535];

    mic1_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ack    (data_ack),
        .data_rdata  (data_rdata),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_rdata (fetch_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_access(input logic we, input logic [15:0] addr, input logic [31:0] wd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wd;
        tick();
        tick();
        chk("host_access_ack", 32'(host_ack), 32'd1);
        host_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] exp_b [4];
        logic [2:0] exp_c [6];
        int n_data, n_fetch;
        logic [1:0] exp_rr;

        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_c = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};

        rst_n = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        fetch_req = 1'b0; fetch_addr = '0;
        #1;
        chk("rst_mem_en",    32'(mem_en), 32'd0);
        chk("rst_mem_we",    32'(mem_we), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_acks",      32'({host_ack, data_ack, fetch_ack}), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_host_rd",   host_rdata, 32'd0);
        chk("rst_data_rd",   data_rdata, 32'd0);
        chk("rst_fetch_rd",  32'(fetch_rdata), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // host write, cycle-by-cycle
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 32'hDEADBEEF;
        tick();
        chk("hw_g_mem_en",    32'(mem_en), 32'd1);
        chk("hw_g_mem_we",    32'(mem_we), 32'd1);
        chk("hw_g_mem_addr",  32'(mem_addr), 32'h10);
        chk("hw_g_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("hw_g_busy",      32'(busy), 32'd1);
        chk("hw_g_ack",       32'(host_ack), 32'd0);
        tick();
        chk("hw_a_ack",    32'(host_ack), 32'd1);
        chk("hw_a_mem_en", 32'(mem_en), 32'd0);
        chk("hw_a_mem_we", 32'(mem_we), 32'd0);
        chk("hw_a_busy",   32'(busy), 32'd0);
        host_req = 1'b0;
        tick();
        chk("hw_ack_drop", 32'(host_ack), 32'd0);

        // host read back
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010; host_wdata = 32'h0;
        tick();
        chk("hr_g_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("hr_ack",   32'(host_ack), 32'd1);
        chk("hr_rdata", host_rdata, 32'hDEADBEEF);
        host_req = 1'b0;
        tick();

        // preload through the host port
        host_access(1'b1, 16'h0004, 32'h11223344);
        host_access(1'b1, 16'h0020, 32'hA0A0A0A0);
        host_access(1'b1, 16'h0021, 32'hB1B1B1B1);
        host_access(1'b1, 16'h0022, 32'hC0C1C2C3);
        host_access(1'b1, 16'h0030, 32'h30303030);
        host_access(1'b1, 16'h0031, 32'h31313131);
        host_access(1'b1, 16'h0040, 32'h12345678);

        // fetch byte lanes of word 4
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = 18'(16 + i);
            tick();
            chk("fetch_mem_addr", 32'(mem_addr), 32'd4);
            chk("fetch_mem_we",   32'(mem_we), 32'd0);
            tick();
            chk("fetch_ack",   32'(fetch_ack), 32'd1);
            chk("fetch_byte",  32'(fetch_rdata), 32'(exp_b[i]));
            fetch_req = 1'b0;
            tick();
            chk("fetch_ack_single", 32'(fetch_ack), 32'd0);
        end

        // three-way contention straight after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        host_req  = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        data_req  = 1'b1; data_we = 1'b0; data_addr = 16'h0021;
        fetch_req = 1'b1; fetch_addr = 18'h00089;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("cont_acks", 32'({host_ack, data_ack, fetch_ack}), 32'(exp_c[c]));
            if (host_ack)  host_req  = 1'b0;
            if (data_ack)  data_req  = 1'b0;
            if (fetch_ack) fetch_req = 1'b0;
        end
        chk("cont_host_rd",  host_rdata, 32'hA0A0A0A0);
        chk("cont_data_rd",  data_rdata, 32'hB1B1B1B1);
        chk("cont_fetch_rd", 32'(fetch_rdata), 32'hC1);
        chk("cont_reqs_left", 32'({host_req, data_req, fetch_req}), 32'd0);
        tick();

        // round-robin between data and fetch held high
        n_data = 0;
        n_fetch = 0;
        data_req  = 1'b1; data_we = 1'b0; data_addr = 16'h0030;
        fetch_req = 1'b1; fetch_addr = 18'h000C4;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c % 4 == 2)      exp_rr = 2'b10;
            else if (c % 4 == 0) exp_rr = 2'b01;
            else                 exp_rr = 2'b00;
            chk("rr_acks", 32'({host_ack, data_ack, fetch_ack}), 32'({1'b0, exp_rr}));
            if (data_ack)  n_data++;
            if (fetch_ack) n_fetch++;
            if (c == 16) begin
                data_req  = 1'b0;
                fetch_req = 1'b0;
            end
        end
        chk("rr_data_count",  32'(n_data), 32'd4);
        chk("rr_fetch_count", 32'(n_fetch), 32'd4);
        chk("rr_data_rd",     data_rdata, 32'h30303030);
        chk("rr_fetch_rd",    32'(fetch_rdata), 32'h31);
        tick();

        // reset during the access cycle of a data read
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0040;
        tick();
        chk("mid_pre_mem_en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_mem_en",   32'(mem_en), 32'd0);
        chk("mid_busy",     32'(busy), 32'd0);
        chk("mid_mem_addr", 32'(mem_addr), 32'd0);
        chk("mid_data_rd",  data_rdata, 32'd0);
        chk("mid_data_ack", 32'(data_ack), 32'd0);
        tick();
        chk("mid_data_ack_later", 32'(data_ack), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_mem_en",   32'(mem_en), 32'd1);
        chk("post_mem_addr", 32'(mem_addr), 32'h40);
        tick();
        chk("post_data_ack", 32'(data_ack), 32'd1);
        chk("post_data_rd",  data_rdata, 32'h12345678);
        data_req = 1'b0;
        tick();

        // idle hold after refreshing host and fetch read data
        host_access(1'b0, 16'h0010, 32'h0);
        fetch_req = 1'b1; fetch_addr = 18'h00013;
        tick();
        tick();
        chk("idle_pre_fetch_ack", 32'(fetch_ack), 32'd1);
        fetch_req = 1'b0;
        tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_en_busy",  32'({mem_en, busy}), 32'd0);
            chk("idle_host_rd",  host_rdata, 32'hDEADBEEF);
            chk("idle_data_rd",  data_rdata, 32'h12345678);
            chk("idle_fetch_rd", 32'(fetch_rdata), 32'h44);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
